pfft_udiv_seq: RTL and testbench



---
 rtl/pfft_div_pkg.sv | 35 +++
 rtl/pfft_udiv_step.sv | 70 +++++++
 rtl/pfft_udiv_seq.sv | 152 +++++++++++++++
 tb/tb_pfft_udiv_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pfft_div_pkg.sv
//------------------------------------------------------------------------------
// pfft_div_pkg
// Shared definitions for the posit FFT unsigned sequential divider.
//   state_t            : divider FSM states (IDLE / CALC / DONE)
//   DEF_DIVIDEND_WIDTH : default dividend / quotient width (full product width)
//   DEF_DIVISOR_WIDTH  : default divisor / remainder width
//   RADIX_LOG2         : quotient bits retired per CALC cycle
//   calc_iter()        : number of CALC cycles for a given width and radix
// Optional feature macro: PFFT_UDIV_RADIX4_EN (two quotient bits per cycle).
//------------------------------------------------------------------------------
`timescale 1ns/1ps

package pfft_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DIVIDEND_WIDTH = 119;
    localparam int DEF_DIVISOR_WIDTH  = 61;

`ifdef PFFT_UDIV_RADIX4_EN
    localparam int RADIX_LOG2 = 2;
`else
    localparam int RADIX_LOG2 = 1;
`endif

    // An odd width under radix-4 is rounded up: the dividend gets a zero MSB.
    function automatic int calc_iter(input int width, input int radix_log2);
        return (width + radix_log2 - 1) / radix_log2;
    endfunction

endpackage

// File: rtl/pfft_udiv_step.sv
//------------------------------------------------------------------------------
// pfft_udiv_step
// One combinational restoring-division step.
//   rem      in  : current partial remainder (always < divisor)
//   din      in  : next dividend bit(s), MSB first
//   d1       in  : divisor
//   d3       in  : 3 * divisor (only with PFFT_UDIV_RADIX4_EN)
//   rem_next out : partial remainder after this step
//   qbits    out : quotient bit(s) produced by this step
// Optional feature macro: PFFT_UDIV_RADIX4_EN selects the radix-4 step.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pfft_udiv_step
    import pfft_div_pkg::*;
#(
    parameter int DIVISOR_WIDTH = DEF_DIVISOR_WIDTH
) (
    input  logic [DIVISOR_WIDTH-1:0] rem,
    input  logic [RADIX_LOG2-1:0]    din,
    input  logic [DIVISOR_WIDTH-1:0] d1,
`ifdef PFFT_UDIV_RADIX4_EN
    input  logic [DIVISOR_WIDTH+1:0] d3,
`endif
    output logic [DIVISOR_WIDTH-1:0] rem_next,
    output logic [RADIX_LOG2-1:0]    qbits
);

    localparam int TW = DIVISOR_WIDTH + RADIX_LOG2;

    // Because rem < divisor, the trial is always < radix * divisor, so at
    // most one subtraction of the chosen multiple is ever needed.
    logic [TW-1:0] trial;
    assign trial = {rem, din};

`ifdef PFFT_UDIV_RADIX4_EN
    logic [TW-1:0] d1x;
    logic [TW-1:0] d2x;
    assign d1x = {2'b00, d1};
    assign d2x = {1'b0, d1, 1'b0};

    always_comb begin
        qbits    = 2'd0;
        rem_next = trial[DIVISOR_WIDTH-1:0];
        if (trial >= d3) begin
            qbits    = 2'd3;
            rem_next = DIVISOR_WIDTH'(trial - d3);
        end else if (trial >= d2x) begin
            qbits    = 2'd2;
            rem_next = DIVISOR_WIDTH'(trial - d2x);
        end else if (trial >= d1x) begin
            qbits    = 2'd1;
            rem_next = DIVISOR_WIDTH'(trial - d1x);
        end
    end
`else
    logic [TW-1:0] d1x;
    assign d1x = {1'b0, d1};

    always_comb begin
        qbits    = 1'b0;
        rem_next = trial[DIVISOR_WIDTH-1:0];
        if (trial >= d1x) begin
            qbits    = 1'b1;
            rem_next = DIVISOR_WIDTH'(trial - d1x);
        end
    end
`endif

endmodule

// File: rtl/pfft_udiv_seq.sv
//------------------------------------------------------------------------------
// pfft_udiv_seq
// Iterative unsigned restoring divider, valid/ready on both sides.
//   ap_clk      in  : clock, rising edge
//   ap_rst_n    in  : asynchronous active-low reset
//   in_valid    in  : dividend/divisor presented
//   in_ready    out : block can accept an operand pair (IDLE)
//   dividend    in  : unsigned dividend, DIVIDEND_WIDTH bits
//   divisor     in  : unsigned divisor, DIVISOR_WIDTH bits
//   out_valid   out : result presented (DONE), held until out_ready
//   out_ready   in  : consumer accepts result
//   quotient    out : unsigned quotient (all ones on zero divisor)
//   remainder   out : unsigned remainder (dividend LSBs on zero divisor)
//   div_by_zero out : result came from a zero divisor
// Latency: ITER cycles from accept to out_valid (1 extra edge to DONE for a
// zero divisor, handled as a single-cycle CALC pass).
// Optional feature macro: PFFT_UDIV_RADIX4_EN (radix-4, ceil(W/2) cycles).
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pfft_udiv_seq
    import pfft_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int ITER = calc_iter(DIVIDEND_WIDTH, RADIX_LOG2);
    localparam int QW   = ITER * RADIX_LOG2;   // dividend padded to whole steps
    localparam int CW   = $clog2(ITER + 1);

    state_t                   state;
    state_t                   state_nxt;
    logic                     accept;
    logic                     step_en;
    logic [CW-1:0]            cnt;
    logic [QW-1:0]            q_sh;            // dividend bits out, quotient bits in
    logic [DIVISOR_WIDTH-1:0] rem_r;
    logic [DIVISOR_WIDTH-1:0] dvs;
    logic [DIVISOR_WIDTH-1:0] rem_next;
    logic [RADIX_LOG2-1:0]    qbits;
    logic                     dbz;

`ifdef PFFT_UDIV_RADIX4_EN
    logic [DIVISOR_WIDTH+1:0] dvs3;
`endif

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs (decoded from the state register only)
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step_en   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                step_en = 1'b1;
                if (cnt == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Divisor (and 3x divisor) held for the whole operation
    always_ff @(posedge ap_clk) begin
        if (accept) begin
            dvs  <= divisor;
`ifdef PFFT_UDIV_RADIX4_EN
            dvs3 <= {1'b0, divisor, 1'b0} + {2'b00, divisor};
`endif
        end
    end

    // Iteration state; a zero divisor takes one CALC cycle that loads the
    // saturated result instead of stepping.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt   <= '0;
            q_sh  <= '0;
            rem_r <= '0;
            dbz   <= 1'b0;
        end else if (accept) begin
            q_sh  <= QW'(dividend);
            rem_r <= '0;
            dbz   <= (divisor == '0);
            cnt   <= (divisor == '0) ? CW'(1) : CW'(ITER);
        end else if (step_en) begin
            cnt <= cnt - CW'(1);
            if (dbz) begin
                q_sh  <= '1;
                rem_r <= q_sh[DIVISOR_WIDTH-1:0];
            end else begin
                q_sh  <= {q_sh[QW-RADIX_LOG2-1:0], qbits};
                rem_r <= rem_next;
            end
        end
    end

    pfft_udiv_step #(
        .DIVISOR_WIDTH (DIVISOR_WIDTH)
    ) u_step (
        .rem      (rem_r),
        .din      (q_sh[QW-1 -: RADIX_LOG2]),
        .d1       (dvs),
`ifdef PFFT_UDIV_RADIX4_EN
        .d3       (dvs3),
`endif
        .rem_next (rem_next),
        .qbits    (qbits)
    );

    assign quotient    = q_sh[DIVIDEND_WIDTH-1:0];
    assign remainder   = rem_r;
    assign div_by_zero = dbz;

endmodule

// File: tb/tb_pfft_udiv_seq.sv
`timescale 1ns/1ps

module tb_pfft_udiv_seq;

    localparam int DW = 119;
    localparam int VW = 61;
`ifdef PFFT_UDIV_RADIX4_EN
    localparam int ITER = 60;
`else
    localparam int ITER = 119;
`endif

    logic          ap_clk    = 1'b0;
    logic          ap_rst_n  = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] dividend  = '0;
    logic [VW-1:0] divisor   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    pfft_udiv_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every accepted output is matched against the oldest expectation
    always @(negedge ap_clk) begin
        if (ap_rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("mon unexpected result", 128'(1), 128'(0));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("mon quotient", 128'(quotient), 128'(e.q));
                chk("mon remainder", 128'(remainder), 128'(e.r));
                chk("mon div_by_zero", 128'(div_by_zero), 128'(e.dbz));
            end
        end
    end

    task automatic do_div(input string name, input logic [DW-1:0] a, input logic [VW-1:0] b,
                          input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edbz,
                          input int elat, input bit hold);
        exp_t          e;
        int            lat;
        int            w;
        logic [DW-1:0] sq;
        logic [VW-1:0] sr;
        logic          sd;
        e.q = eq;
        e.r = er;
        e.dbz = edbz;
        sbq.push_back(e);
        out_ready = !hold;
        w = 0;
        while (!in_ready && w < 10) begin
            @(posedge ap_clk); #1;
            w++;
        end
        chk({name, " in_ready before accept"}, 128'(in_ready), 128'(1));
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        dividend = DW'({$urandom, $urandom, $urandom, $urandom});
        divisor  = VW'({$urandom, $urandom});
        lat = 0;
        while (!out_valid && lat < 2 * ITER + 10) begin
            @(posedge ap_clk); #1;
            lat++;
        end
        chk({name, " latency"}, 128'(lat), 128'(elat));
        if (hold) begin
            sq = quotient;
            sr = remainder;
            sd = div_by_zero;
            for (int i = 0; i < 10; i++) begin
                in_valid = 1'b1;
                dividend = DW'(i + 3);
                divisor  = VW'(i + 1);
                @(posedge ap_clk); #1;
                chk({name, " hold quotient"}, 128'(quotient), 128'(sq));
                chk({name, " hold remainder"}, 128'(remainder), 128'(sr));
                chk({name, " hold dbz"}, 128'(div_by_zero), 128'(sd));
                chk({name, " hold in_ready"}, 128'(in_ready), 128'(0));
                chk({name, " hold out_valid"}, 128'(out_valid), 128'(1));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge ap_clk); #1;
        chk({name, " in_ready after handshake"}, 128'(in_ready), 128'(1));
        chk({name, " out_valid after handshake"}, 128'(out_valid), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("reset quotient", 128'(quotient), 128'(0));
        chk("reset remainder", 128'(remainder), 128'(0));
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset dbz", 128'(div_by_zero), 128'(0));
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        chk("reset in_ready", 128'(in_ready), 128'(1));

        do_div("100/7", DW'(100), VW'(7), DW'(14), VW'(2), 1'b0, ITER, 1'b0);
        do_div("max/1", {DW{1'b1}}, VW'(1), {DW{1'b1}}, VW'(0), 1'b0, ITER, 1'b0);
        do_div("5/2^60", DW'(5), 61'h1000_0000_0000_0000, DW'(0), VW'(5), 1'b0, ITER, 1'b0);
        do_div("0x1234/0", DW'(16'h1234), VW'(0), {DW{1'b1}}, VW'(16'h1234), 1'b1, 1, 1'b0);
        do_div("max/maxdiv", {DW{1'b1}}, {VW{1'b1}}, 119'h400_0000_0000_0000,
               61'h3FF_FFFF_FFFF_FFFF, 1'b0, ITER, 1'b0);
        do_div("12345/123", DW'(12345), VW'(123), DW'(100), VW'(45), 1'b0, ITER, 1'b0);
        do_div("7/7", DW'(7), VW'(7), DW'(1), VW'(0), 1'b0, ITER, 1'b0);
        do_div("max/0", {DW{1'b1}}, VW'(0), {DW{1'b1}}, {VW{1'b1}}, 1'b1, 1, 1'b0);
        do_div("3/5 hold", DW'(3), VW'(5), DW'(0), VW'(3), 1'b0, ITER, 1'b1);

        // Reset in the middle of an operation; that result is never expected
        out_ready = 1'b1;
        dividend  = DW'(100);
        divisor   = VW'(7);
        in_valid  = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        repeat (50) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("midreset quotient", 128'(quotient), 128'(0));
        chk("midreset remainder", 128'(remainder), 128'(0));
        chk("midreset out_valid", 128'(out_valid), 128'(0));
        chk("midreset dbz", 128'(div_by_zero), 128'(0));
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        chk("midreset in_ready", 128'(in_ready), 128'(1));
        chk("midreset out_valid after", 128'(out_valid), 128'(0));

        do_div("1000/10", DW'(1000), VW'(10), DW'(100), VW'(0), 1'b0, ITER, 1'b0);

        repeat (3) @(posedge ap_clk);
        #1;
        chk("scoreboard drained", 128'(sbq.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
